// File: rtl/iob_bus_merge2_pkg.sv
// Shared definitions for the two-master IOb bus merge: FSM encoding, master ids,
// and the round-robin pick used by the arbiter.
package iob_bus_merge2_pkg;

  localparam int unsigned MID_W = 1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WAIT_RD = 1'b1
  } state_t;

  localparam logic [MID_W-1:0] MID_M0 = 1'b0;
  localparam logic [MID_W-1:0] MID_M1 = 1'b1;

  // Round-robin pick: a lone requester wins; on a tie the master not granted last wins.
  function automatic logic [MID_W-1:0] rr_pick(input logic             req0,
                                               input logic             req1,
                                               input logic [MID_W-1:0] last);
    if (req0 && req1) begin
      return (last == MID_M0) ? MID_M1 : MID_M0;
    end else if (req1) begin
      return MID_M1;
    end else begin
      return MID_M0;
    end
  endfunction

endpackage

// File: rtl/iob_reg.sv
// Generic register with synchronous active-high reset and clock enable.
// Reset takes effect regardless of the clock enable.
module iob_reg #(
  parameter int unsigned        DATA_W  = 1,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  // Hold value unless reset or enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= RST_VAL;
    end else if (cke_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_bus_merge2.sv
// Merges two IOb native masters (m0 instruction, m1 data) onto a single slave
// port. One transaction in flight: writes finish in the acceptance cycle, reads
// park the FSM in WAIT_RD until the slave returns rvalid.
module iob_bus_merge2
  import iob_bus_merge2_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,

  input  logic                m0_avalid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rvalid,
  output logic                m0_ready,

  input  logic                m1_avalid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rvalid,
  output logic                m1_ready,

  output logic                s_avalid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rvalid,
  input  logic                s_ready,

  output logic                busy_o
);

  state_t           state_q, state_d;
  logic [0:0]       state_raw;
  logic [MID_W-1:0] owner_q, owner_d;
  logic [MID_W-1:0] last_q, last_d;
  logic [MID_W-1:0] gnt;

  // FSM state register.
  iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_state_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cke_i  (cke_i),
    .data_i (state_d),
    .data_o (state_raw)
  );

  assign state_q = state_t'(state_raw);

  // Id of the master whose read is outstanding.
  iob_reg #(.DATA_W(MID_W), .RST_VAL(MID_M0)) u_owner_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cke_i  (cke_i),
    .data_i (owner_d),
    .data_o (owner_q)
  );

  // Last accepted master; resets to m1 so m0 wins the first tie.
  iob_reg #(.DATA_W(MID_W), .RST_VAL(MID_M1)) u_last_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cke_i  (cke_i),
    .data_i (last_d),
    .data_o (last_q)
  );

  // Read data is broadcast; only rvalid qualifies it.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  // Arbitration, request/response routing and next-state logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt       = rr_pick(m0_avalid, m1_avalid, last_q);
    s_avalid  = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    busy_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_avalid || m1_avalid) begin
          s_avalid = 1'b1;
          if (gnt == MID_M1) begin
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
            m1_ready = s_ready;
          end else begin
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
            m0_ready = s_ready;
          end
          // Accepted: remember the winner; reads wait for their response.
          if (s_ready) begin
            last_d = gnt;
            if (s_wstrb == '0) begin
              state_d = ST_WAIT_RD;
              owner_d = gnt;
            end
          end
        end
      end

      ST_WAIT_RD: begin
        busy_o = 1'b1;
        if (owner_q == MID_M1) begin
          m1_rvalid = s_rvalid;
        end else begin
          m0_rvalid = s_rvalid;
        end
        if (s_rvalid) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iob_bus_merge2.sv
// Directed bench for iob_bus_merge2: reads, writes, round-robin ties,
// blocking during WAIT_RD, reset mid-read and clock-enable hold.
module tb_iob_bus_merge2;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WS_W   = DATA_W / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cke_i;
  logic              m0_avalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [WS_W-1:0]   m0_wstrb;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_rvalid;
  logic              m0_ready;
  logic              m1_avalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [WS_W-1:0]   m1_wstrb;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_rvalid;
  logic              m1_ready;
  logic              s_avalid;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [WS_W-1:0]   s_wstrb;
  logic [DATA_W-1:0] s_rdata;
  logic              s_rvalid;
  logic              s_ready;
  logic              busy_o;

  int n_vec = 0;
  int n_err = 0;

  iob_bus_merge2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cke_i     (cke_i),
    .m0_avalid (m0_avalid),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_rdata  (m0_rdata),
    .m0_rvalid (m0_rvalid),
    .m0_ready  (m0_ready),
    .m1_avalid (m1_avalid),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_rdata  (m1_rdata),
    .m1_rvalid (m1_rvalid),
    .m1_ready  (m1_ready),
    .s_avalid  (s_avalid),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_rdata   (s_rdata),
    .s_rvalid  (s_rvalid),
    .s_ready   (s_ready),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Hard stop in case the sequence never reaches its end.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; cke_i = 1'b1;
    m0_avalid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_avalid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_rdata = '0; s_rvalid = 1'b0; s_ready = 1'b0;

    // Reset: everything quiet.
    tick(); tick();
    chk("rst_s_avalid", s_avalid, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_ready", m1_ready, 0);
    chk("rst_rvalids", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    tick();
    chk("post_rst_busy", busy_o, 0);

    // m0 read of 0x100, response three cycles after acceptance.
    m0_avalid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0; s_ready = 1'b1; #1;
    chk("rd0_s_avalid", s_avalid, 1);
    chk("rd0_s_addr", s_addr, 32'h100);
    chk("rd0_m0_ready", m0_ready, 1);
    chk("rd0_m1_ready", m1_ready, 0);
    tick();
    m0_avalid = 1'b0; s_ready = 1'b0; #1;
    chk("rd0_c1_busy", busy_o, 1);
    chk("rd0_c1_rvalid", m0_rvalid, 0);
    chk("rd0_c1_s_avalid", s_avalid, 0);
    tick();
    chk("rd0_c2_busy", busy_o, 1);
    tick();
    s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF; #1;
    chk("rd0_c3_busy", busy_o, 1);
    chk("rd0_m0_rvalid", m0_rvalid, 1);
    chk("rd0_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd0_m1_rvalid", m1_rvalid, 0);
    tick();
    s_rvalid = 1'b0; #1;
    chk("rd0_done_busy", busy_o, 0);
    chk("rd0_done_rvalid", m0_rvalid, 0);

    // Round robin from reset: m0, m1, m0, m1.
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    m0_avalid = 1'b1; m0_addr = 32'hA0; m0_wstrb = 4'h0;
    m1_avalid = 1'b1; m1_addr = 32'hB0; m1_wstrb = 4'h0;
    s_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("rr_m0_ready", m0_ready, (t % 2 == 0) ? 1 : 0);
      chk("rr_m1_ready", m1_ready, (t % 2 == 1) ? 1 : 0);
      chk("rr_s_addr", s_addr, (t % 2 == 0) ? 32'hA0 : 32'hB0);
      tick();
      s_rvalid = 1'b1; s_rdata = 32'h1000 + t; #1;
      chk("rr_wait_ready", {m0_ready, m1_ready}, 0);
      chk("rr_m0_rvalid", m0_rvalid, (t % 2 == 0) ? 1 : 0);
      chk("rr_m1_rvalid", m1_rvalid, (t % 2 == 1) ? 1 : 0);
      tick();
      s_rvalid = 1'b0;
    end
    m0_avalid = 1'b0; m1_avalid = 1'b0; s_ready = 1'b0;
    tick();

    // m1 write completes in its acceptance cycle; m0 read accepted right after.
    m1_avalid = 1'b1; m1_addr = 32'h8; m1_wdata = 32'h12345678; m1_wstrb = 4'hF;
    s_ready = 1'b1; #1;
    chk("wr_m1_ready", m1_ready, 1);
    chk("wr_s_wdata", s_wdata, 32'h12345678);
    chk("wr_s_wstrb", s_wstrb, 4'hF);
    chk("wr_s_addr", s_addr, 32'h8);
    tick();
    m1_avalid = 1'b0; m1_wstrb = 4'h0;
    m0_avalid = 1'b1; m0_addr = 32'h200; m0_wstrb = 4'h0; #1;
    chk("wr_idle_busy", busy_o, 0);
    chk("wr_next_m0_ready", m0_ready, 1);
    chk("wr_next_s_addr", s_addr, 32'h200);
    tick();
    m0_avalid = 1'b0; #1;
    chk("wr_next_busy", busy_o, 1);
    s_rvalid = 1'b1; tick(); s_rvalid = 1'b0;

    // m1 read outstanding blocks a new m0 request until after rvalid.
    m1_avalid = 1'b1; m1_addr = 32'h40; s_ready = 1'b1; #1;
    chk("blk_m1_ready", m1_ready, 1);
    tick();
    m1_avalid = 1'b0; m0_avalid = 1'b1; m0_addr = 32'h300; #1;
    chk("blk_s_avalid", s_avalid, 0);
    chk("blk_m0_ready", m0_ready, 0);
    tick();
    chk("blk2_m0_ready", m0_ready, 0);
    s_rvalid = 1'b1; s_rdata = 32'h55AA55AA; #1;
    chk("blk_m1_rvalid", m1_rvalid, 1);
    chk("blk_m0_rvalid", m0_rvalid, 0);
    chk("blk_rv_m0_ready", m0_ready, 0);
    chk("blk_rv_s_avalid", s_avalid, 0);
    tick();
    s_rvalid = 1'b0; #1;
    chk("blk_after_m0_ready", m0_ready, 1);
    chk("blk_after_s_addr", s_addr, 32'h300);
    tick();
    m0_avalid = 1'b0; s_ready = 1'b0; #1;
    chk("blk_m0_wait_busy", busy_o, 1);

    // Reset pulse abandons m0 read; stale rvalid two cycles later is ignored.
    rst_i = 1'b1; tick(); rst_i = 1'b0; #1;
    chk("rstmid_busy", busy_o, 0);
    tick();
    s_rvalid = 1'b1; #1;
    chk("stale_m0_rvalid", m0_rvalid, 0);
    chk("stale_m1_rvalid", m1_rvalid, 0);
    chk("stale_busy", busy_o, 0);
    tick();
    s_rvalid = 1'b0;
    m0_avalid = 1'b1; m0_addr = 32'hC0; m1_avalid = 1'b1; m1_addr = 32'hD0; #1;
    chk("tie_noready_s_addr", s_addr, 32'hC0);
    chk("tie_noready_m0_ready", m0_ready, 0);
    s_ready = 1'b1; #1;
    chk("tie_m0_ready", m0_ready, 1);
    chk("tie_m1_ready", m1_ready, 0);
    tick();
    m0_avalid = 1'b0; m1_avalid = 1'b0; s_ready = 1'b0;

    // Clock enable low in WAIT_RD freezes everything.
    cke_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("cke_busy", busy_o, 1);
    end
    cke_i = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hCAFEF00D; #1;
    chk("cke_m0_rvalid", m0_rvalid, 1);
    chk("cke_m1_rvalid", m1_rvalid, 0);
    chk("cke_rdata", m0_rdata, 32'hCAFEF00D);
    tick();
    s_rvalid = 1'b0; #1;
    chk("cke_done_busy", busy_o, 0);

    // Request without ready is not locked: dropping avalid hands the port over.
    m1_avalid = 1'b1; m1_addr = 32'hE0; #1;
    chk("nolock_s_addr1", s_addr, 32'hE0);
    tick();
    m1_avalid = 1'b0; m0_avalid = 1'b1; m0_addr = 32'hF0; #1;
    chk("nolock_s_addr0", s_addr, 32'hF0);
    m0_avalid = 1'b0; #1;
    chk("nolock_idle", s_avalid, 0);

    // Clock enable low in IDLE blocks acceptance.
    cke_i = 1'b0; m1_avalid = 1'b1; s_ready = 1'b1;
    tick();
    m1_avalid = 1'b0; s_ready = 1'b0; #1;
    chk("cke_idle_busy", busy_o, 0);
    cke_i = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iob_bus_merge2.md
IOB_BUS_MERGE2 -- requirements
Module: iob_bus_merge2

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both masters and the slave.
REQ-002 Parameter DATA_W, default 32, data width; WSTRB_W = DATA_W/8.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 cke_i  input  1  clock enable; when 0 all internal state holds.
REQ-006 m0_avalid, m0_addr, m0_wdata, m0_wstrb  input  1, ADDR_W, DATA_W, WSTRB_W  master 0 (instruction bus) request.
REQ-007 m0_rdata, m0_rvalid, m0_ready  output  DATA_W, 1, 1  master 0 response.
REQ-008 m1_avalid, m1_addr, m1_wdata, m1_wstrb  input  1, ADDR_W, DATA_W, WSTRB_W  master 1 (data bus) request.
REQ-009 m1_rdata, m1_rvalid, m1_ready  output  DATA_W, 1, 1  master 1 response.
REQ-010 s_avalid, s_addr, s_wdata, s_wstrb  output  1, ADDR_W, DATA_W, WSTRB_W  merged request to the single memory port.
REQ-011 s_rdata, s_rvalid, s_ready  input  DATA_W, 1, 1  memory response.
REQ-012 busy_o  output  1  high while a read is outstanding.

Function
REQ-013 Block SHALL merge two IOb native masters onto one slave port, one transaction in flight at a time.
REQ-014 FSM states SHALL be IDLE and WAIT_RD only.
REQ-015 In IDLE, grant SHALL be combinational: only one master requesting -> that master; both requesting -> master not granted last (round-robin).
REQ-016 In IDLE, granted master's avalid/addr/wdata/wstrb SHALL drive s_*; s_ready SHALL route only to granted master's m_ready; other master's m_ready = 0.
REQ-017 No master requesting in IDLE: s_avalid = 0, s_addr/s_wdata/s_wstrb = 0.
REQ-018 Acceptance = s_avalid & s_ready in IDLE with cke_i = 1; last-granted register SHALL update to accepted master.
REQ-019 Accepted write (|wstrb != 0) SHALL complete in the acceptance cycle; FSM stays IDLE; next request may be accepted the following cycle.
REQ-020 Accepted read (wstrb == 0) SHALL latch owner id and move to WAIT_RD next cycle.
REQ-021 In WAIT_RD: s_avalid = 0, m0_ready = m1_ready = 0, busy_o = 1.
REQ-022 In WAIT_RD, s_rvalid SHALL drive owner's m_rvalid combinationally (zero latency); non-owner m_rvalid = 0; FSM returns to IDLE next cycle.
REQ-023 m0_rdata and m1_rdata SHALL both equal s_rdata; only m_rvalid qualifies data.
REQ-024 s_rvalid in IDLE SHALL be ignored (no m_rvalid asserted); slave never asserts rvalid in acceptance cycle.
REQ-025 Request without s_ready SHALL hold grant combinationally only; grant is not locked, so a master dropping avalid releases the port.
REQ-026 Read latency is unbounded; FSM SHALL wait in WAIT_RD indefinitely.

Reset
REQ-027 rst_i = 1 at a clock edge SHALL force IDLE, owner = 0, last-granted = 1 (master 0 wins first tie), regardless of cke_i.
REQ-028 Reset mid-read SHALL abandon the outstanding read; a later s_rvalid in IDLE is ignored per REQ-024.
REQ-029 During and after reset all outputs SHALL be 0 until a master requests.

Structure
REQ-030 FSM state encodings and master-id width SHALL live in the shared bus package/header with the IOb request/response field macros.
REQ-031 State, owner and last-granted registers SHALL use iob_reg instances; no other sub-module.
REQ-032 Target size 120-250 lines RTL; no latches; combinational outputs from one always block or continuous assigns.

Verification
REQ-033 m0 read addr 0x100, s_ready=1, s_rvalid 3 cycles later with 0xDEADBEEF -> m0_rvalid=1 once, m0_rdata=0xDEADBEEF, m1_rvalid=0, busy_o high 3 cycles.
REQ-034 m0 and m1 both read from reset -> m0 served first, then m1; repeat both -> m1 first (alternation over 4 transactions).
REQ-035 m1 write addr 0x8, wdata 0x12345678, wstrb 0xF, s_ready=1 -> m1_ready=1 same cycle, FSM stays IDLE, m0 read accepted next cycle.
REQ-036 m1 read pending in WAIT_RD, m0 asserts avalid -> s_avalid=0, m0_ready=0 until cycle after s_rvalid; then m0 accepted.
REQ-037 rst_i pulsed 1 cycle in WAIT_RD, stale s_rvalid 2 cycles later -> no m_rvalid, busy_o=0, next tie grants m0.
REQ-038 cke_i=0 for 5 cycles in WAIT_RD with s_rvalid=0 -> state, owner, busy_o unchanged; resumes correctly on cke_i=1.
